// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry and helpers for the write-back path.
// Macros are shared with the register file; the package re-exports them as typed constants.
`ifndef REGFILE_DEFS_SV
`define REGFILE_DEFS_SV
`define REG_AW   5
`define REG_DW   32
`define REG_ZERO 5'd0
`endif

package regfile_wb_arbiter_pkg;

    localparam int REG_AW = `REG_AW;
    localparam int REG_DW = `REG_DW;

    localparam logic [REG_AW-1:0] REG_ZERO = `REG_ZERO;

    // Next round-robin pointer after a grant to index idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid bit scanning ptr, ptr+1, ... mod N_REQ.
// Emits a one-hot grant, its encoded index and an any-grant flag.
module regfile_wb_arbiter_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             any
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!any && valid[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file's single write port.
// Grant is combinational; the port (WE3/A3/WD3/wb_id) is registered one cycle after the handshake.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int N_REQ = 2,
    parameter  int AW    = REG_AW,
    parameter  int DW    = REG_DW,
    parameter  int CW    = 16,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic                WE3,
    output logic [AW-1:0]       A3,
    output logic [DW-1:0]       WD3,
    output logic [PW-1:0]       wb_id,
    output logic [CW-1:0]       conflict_cnt
);

    logic [PW-1:0]    ptr;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    gidx;
    logic             gany;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             contended;

    // Reset also masks requests so a grant seen during reset is never acknowledged.
    assign cand      = (hold || rst) ? '0 : req_valid;
    assign req_ready = grant;
    assign contended = !hold && ($countones(req_valid) >= 2);

    regfile_wb_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .valid (cand),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign sel_addr = req_addr[gidx*AW +: AW];
    assign sel_data = req_data[gidx*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gany) begin
            ptr <= PW'(rr_next(int'(gidx), N_REQ));
        end
    end

    // x0 writes are acknowledged to free the source but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3   <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
            wb_id <= '0;
        end else if (gany) begin
            WE3   <= (sel_addr != AW'(REG_ZERO));
            A3    <= sel_addr;
            WD3   <= sel_data;
            wb_id <= gidx;
        end else begin
            WE3   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (contended && (conflict_cnt != {CW{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a reference round-robin model queues expected commits, popped after each edge.
module tb_regfile_wb_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [DW-1:0]   WD3;
    logic [0:0]      wb_id;
    logic [CW-1:0]   conflict_cnt;

    regfile_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .WE3          (WE3),
        .A3           (A3),
        .WD3          (WD3),
        .wb_id        (wb_id),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            id;
    } commit_t;

    commit_t q[$];
    int      n_chk  = 0;
    int      n_fail = 0;
    int      m_ptr  = 0;
    int      m_cnt  = 0;
    commit_t last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 0;
        q.delete();
        last = '{we: 1'b0, a: '0, d: '0, id: 0};
    endtask

    // One cycle: check the combinational grant, then the registered port after the edge.
    task automatic step(input string tag);
        logic [N-1:0] g;
        logic [N-1:0] vv;
        int           j;
        int           gi;
        commit_t      e;
        #2;
        g  = '0;
        gi = -1;
        vv = hold ? '0 : req_valid;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (gi < 0 && vv[j]) begin
                gi   = j;
                g[j] = 1'b1;
            end
        end
        check({tag, ".ready"}, 64'(req_ready), 64'(g));
        if (gi >= 0) begin
            e.a  = req_addr[gi*AW +: AW];
            e.d  = req_data[gi*DW +: DW];
            e.we = (e.a != 0);
            e.id = gi;
            q.push_back(e);
            m_ptr = (gi + 1) % N;
        end
        if (!hold && $countones(req_valid) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            last = q.pop_front();
        end else begin
            last.we = 1'b0;
        end
        check({tag, ".WE3"},   64'(WE3),          64'(last.we));
        check({tag, ".A3"},    64'(A3),           64'(last.a));
        check({tag, ".WD3"},   64'(WD3),          64'(last.d));
        check({tag, ".wb_id"}, 64'(wb_id),        64'(last.id));
        check({tag, ".cnt"},   64'(conflict_cnt), 64'(m_cnt));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".WE3"},   64'(WE3),          64'(0));
        check({tag, ".A3"},    64'(A3),           64'(0));
        check({tag, ".WD3"},   64'(WD3),          64'(0));
        check({tag, ".wb_id"}, 64'(wb_id),        64'(0));
        check({tag, ".cnt"},   64'(conflict_cnt), 64'(0));
        check({tag, ".ready"}, 64'(req_ready),    64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;

        // Single request from requester 0.
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step("single");
        set_req(0, 1'b0, 5'd0, 32'h0);
        step("single_idle");
        set_req(0, 1'b1, 5'd7, 32'h01234567);
        step("single2");
        set_req(0, 1'b0, 5'd0, 32'h0);

        // Asynchronous reset while WE3 is high, with requester 1 still asking.
        set_req(1, 1'b1, 5'd9, 32'hCAFE0001);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        check("arst_edge.WE3", 64'(WE3), 64'(0));
        rst = 1'b0;
        model_reset();
        step("post_rst");
        set_req(1, 1'b0, 5'd0, 32'h0);

        // Contention from reset: alternate 0,1,0,1.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        for (int i = 0; i < 4; i++) step("contend");
        check("contend.cnt4", 64'(conflict_cnt), 64'(4));
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        step("contend_idle");

        // Write to x0 is accepted but not performed.
        set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        step("x0");
        set_req(1, 1'b0, 5'd0, 32'h0);
        step("x0_idle");

        // Hold with ptr pointing at requester 1.
        set_req(0, 1'b1, 5'd3, 32'h33);
        step("ptr1");
        set_req(0, 1'b1, 5'd4, 32'h44);
        set_req(1, 1'b1, 5'd6, 32'h66);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step("hold");
        hold = 1'b0;
        step("unhold");
        check("unhold.first", 64'(wb_id), 64'(1));

        // Saturation of the conflict counter.
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1'b1, 5'(i + 1), 32'(i));
            set_req(1, 1'b1, 5'(i + 10), 32'(i + 100));
            step("sat");
        end
        check("sat.cnt15", 64'(conflict_cnt), 64'(15));
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        step("sat_idle");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port (WE3/A3/WD3). It shares the port between N_REQ write-back sources (e.g. ALU result, load data) using round-robin arbitration with a valid/ready handshake. Its outputs are registered and connect directly to the register file's write port, one write per clock. It sits between the pipeline's write-back sources and the register file.

## Interface
- N_REQ, 2, number of requesters; legal range 2..8.
- AW, 5, register address width.
- DW, 32, data width.
- CW, 16, conflict counter width.
- PW, derived, equals clog2(N_REQ); not user-set.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- hold  in  1  freeze; while 1, no grant is issued.
- req_valid  in  N_REQ  per-requester write request.
- req_ready  out  N_REQ  per-requester grant; combinational.
- req_addr  in  N_REQ*AW  destination register; requester i occupies bits [i*AW +: AW].
- req_data  in  N_REQ*DW  write data; requester i occupies bits [i*DW +: DW].
- WE3  out  1  register-file write enable; registered.
- A3  out  AW  register-file write address; registered.
- WD3  out  DW  register-file write data; registered.
- wb_id  out  PW  index of the requester whose write is on A3/WD3 this cycle; registered.
- conflict_cnt  out  CW  saturating count of contended cycles.

## Operation
- **Handshake.** A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - A requester holds valid, addr and data stable until the transfer completes.
  - Valid must not drop before ready is seen.
- **Arbitration.** Priority pointer ptr (PW bits).
  - The grant goes to the first valid requester scanning ptr, ptr+1, … mod N_REQ.
  - At most one bit of req_ready is 1.
  - After a grant to requester i, ptr becomes (i+1) mod N_REQ.
  - With no grant, ptr is unchanged.
- **Hold or reset.** While hold=1 or rst=1: req_ready is all 0, no grant is issued, and ptr is unchanged.
- **Commit.** On the clock edge after a grant to requester i:
  - A3 ← addr_i, WD3 ← data_i, wb_id ← i.
  - WE3 ← 1 if addr_i≠0, otherwise 0.
- **Writes to x0.** A write to register 0 is still accepted (ready=1), so the requester is not stalled. The write itself is dropped.
- **Idle cycles.** In a cycle with no grant, WE3 ← 0 on the next edge. A3, WD3 and wb_id keep their previous values.
- **Conflict counter.** conflict_cnt increments on each edge where hold=0 and two or more req_valid bits are 1. It saturates at 2^CW−1 and never wraps.
- **Same address from two requesters.** No special handling; the requests are serialized in grant order.
- **Reset values.**
  - WE3=0, A3=0, WD3=0, wb_id=0, ptr=0, conflict_cnt=0.
  - All outputs take these values immediately on rst assertion, with no clock edge needed.
- **Reset mid-operation.** A grant given in the cycle reset asserts does not commit. The requester keeps valid and re-arbitrates after reset releases.

## Timing
- Grant latency is 0 cycles: req_ready is combinational from req_valid, hold, rst and ptr.
- Commit latency is 1 cycle: WE3/A3/WD3 are valid in the cycle after the handshake. The register file captures them on the following edge.
- Throughput is one write per cycle.
- With K requesters continuously valid, each is granted exactly once every K cycles.
- Read-after-write in the same cycle as WE3 returns the old value; bypassing is the consumer's responsibility.
- hold 1→0: a grant is possible in the same cycle hold falls.

## Structure
- Shared include file holds `REG_AW` (5), `REG_DW` (32) and `REG_ZERO` (5'd0); the register file and this block both use them.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant and encoded index.
  - Reused by any future read-port arbiter.
- Everything else is top level:
  - The output register stage.
  - The ptr update.
  - The saturating counter.

## Test plan
1. **Reset.** Assert rst mid-cycle with the WE3 output register loaded (WE3=1, i.e. a commit in progress) → WE3, A3, WD3, wb_id and conflict_cnt all read 0 before the next clk edge; req_ready=0.
2. **Single request.** req0 valid, addr=5, data=0xDEADBEEF, hold=0 → req_ready=01 in the same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF, wb_id=0; the following cycle WE3=0.
3. **Contention.** req0 (addr 1, 0x11) and req1 (addr 2, 0x22) held valid for 4 cycles from reset → grants 0,1,0,1; A3 sequence 1,2,1,2 one cycle later; conflict_cnt=4.
4. **Write to x0.** req1 valid, addr=0, data=0xFFFFFFFF → req_ready=10; next cycle WE3=0, A3=0, wb_id=1; the requester is released.
5. **Hold.** Both valid, ptr=1, hold=1 for 3 cycles → req_ready=00, WE3=0, conflict_cnt unchanged. Release hold → req1 granted first.
6. **Saturation.** With CW=4, both requesters valid for 20 cycles → conflict_cnt reaches 15 and stays at 15.
